// File: rtl/led_fade_sequencer.sv
// Frame-aligned RGB fade controller feeding the PWM block's duty inputs.
// Ramps each channel toward a commanded target once per frame, then holds.
module led_fade_sequencer #(
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned STEP_W     = 4,
  parameter int unsigned HOLD_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_red,
  input  logic [9:0]        cmd_green,
  input  logic [9:0]        cmd_blue,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  output logic [9:0]        data_red,
  output logic [9:0]        data_green,
  output logic [9:0]        data_blue,
  output logic              frame_start,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DATA_W = 10;
  localparam int unsigned CALC_W = DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [FRAME_BITS-1:0] frame_cnt;
  logic [DATA_W-1:0]   tgt_r, tgt_g, tgt_b;
  logic [STEP_W-1:0]   step_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0]   upd_r, upd_g, upd_b;
  logic                frame_end;
  logic                all_at;
  logic                accept;
  logic                data_en;
  logic                done_d;

  // One channel's per-frame move toward its target; 11-bit math so it never wraps.
  function automatic logic [DATA_W-1:0] step_toward(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] tgt,
                                                    input logic [STEP_W-1:0] st);
    logic [CALC_W-1:0] cur_w, tgt_w, st_w, sum;
    logic [DATA_W-1:0] res;
    cur_w = CALC_W'(cur);
    tgt_w = CALC_W'(tgt);
    st_w  = CALC_W'(st);
    sum   = cur_w + st_w;
    res   = cur;
    if (st == '0) begin
      res = tgt;
    end else if (cur_w < tgt_w) begin
      res = (sum > tgt_w) ? tgt : DATA_W'(sum);
    end else if (cur_w > tgt_w) begin
      res = (cur_w < tgt_w + st_w) ? tgt : DATA_W'(cur_w - st_w);
    end
    return res;
  endfunction

  assign frame_end   = (frame_cnt == '1);
  assign frame_start = (frame_cnt == '0);
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = !cmd_ready;

  assign upd_r  = step_toward(data_red,   tgt_r, step_q);
  assign upd_g  = step_toward(data_green, tgt_g, step_q);
  assign upd_b  = step_toward(data_blue,  tgt_b, step_q);
  assign all_at = (upd_r == tgt_r) && (upd_g == tgt_g) && (upd_b == tgt_b);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over a coincident frame_end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = FADE;
      end
      FADE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (frame_end && all_at) begin
          state_d = (hold_q == '0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (frame_end && (hold_cnt_q == HOLD_W'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    accept     = 1'b0;
    data_en    = 1'b0;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;
    if (state_q == IDLE) begin
      accept = cmd_valid;
    end
    if ((state_q == FADE) && frame_end && !abort) begin
      data_en = 1'b1;
    end
    if ((state_q == FADE) && (state_d == HOLD)) begin
      hold_cnt_d = hold_q;
    end else if ((state_q == HOLD) && frame_end && !abort) begin
      hold_cnt_d = hold_cnt_q - HOLD_W'(1);
    end
    if ((state_q != IDLE) && (state_d == IDLE) && !abort) begin
      done_d = 1'b1;
    end
  end

  // Free-running frame counter, colour registers and command latches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      data_red   <= '0;
      data_green <= '0;
      data_blue  <= '0;
      tgt_r      <= '0;
      tgt_g      <= '0;
      tgt_b      <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      done       <= 1'b0;
    end else begin
      frame_cnt  <= frame_cnt + FRAME_BITS'(1);
      hold_cnt_q <= hold_cnt_d;
      done       <= done_d;
      if (accept) begin
        tgt_r  <= cmd_red;
        tgt_g  <= cmd_green;
        tgt_b  <= cmd_blue;
        step_q <= cmd_step;
        hold_q <= cmd_hold;
      end
      if (data_en) begin
        data_red   <= upd_r;
        data_green <= upd_g;
        data_blue  <= upd_b;
      end
    end
  end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer with 16-clock frames: command/frame
// vector table plus hand sequences for abort, held commands and reset mid-hold.
module tb_led_fade_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_red, cmd_green, cmd_blue;
  logic [3:0] cmd_step;
  logic [7:0] cmd_hold;
  logic       abort;
  logic [9:0] data_red, data_green, data_blue;
  logic       frame_start, busy, done;

  int checks = 0;
  int failures = 0;
  int dcount = 0;
  logic [3:0]  fc_m = 4'd0;
  logic [29:0] prev_data = '0;
  logic        prev_done = 1'b0;

  typedef struct packed {
    bit         is_cmd;
    logic [9:0] r, g, b;
    logic [3:0] st;
    logic [7:0] hd;
    logic [9:0] er, eg, eb;
    bit         ebusy;
    bit         edone;
  } vec_t;

  vec_t tbl[$];

  led_fade_sequencer #(.FRAME_BITS(4), .STEP_W(4), .HOLD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_red(cmd_red), .cmd_green(cmd_green), .cmd_blue(cmd_blue),
    .cmd_step(cmd_step), .cmd_hold(cmd_hold), .abort(abort),
    .data_red(data_red), .data_green(data_green), .data_blue(data_blue),
    .frame_start(frame_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference frame counter
  always @(posedge clk) fc_m <= rst_n ? fc_m + 4'd1 : 4'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("frame_start", int'(frame_start), int'(fc_m == 4'd0));
    if (fc_m != 4'd0) chk("mid_frame_stable", int'({data_red, data_green, data_blue}), int'(prev_data));
    if (done) begin
      dcount++;
      chk("done_width", int'(prev_done), 0);
    end
    prev_data = {data_red, data_green, data_blue};
    prev_done = done;
  endtask

  task automatic wait_frame();
    int n = 0;
    cyc();
    while (fc_m != 4'd0 && n < 40) begin
      cyc();
      n++;
    end
    chk("frame_align", int'(fc_m), 0);
  endtask

  task automatic drive_cmd(input int r, input int g, input int b, input int st, input int hd);
    cmd_red   = 10'(r);
    cmd_green = 10'(g);
    cmd_blue  = 10'(b);
    cmd_step  = 4'(st);
    cmd_hold  = 8'(hd);
  endtask

  task automatic chk_rgb(input string tag, input int r, input int g, input int b);
    chk({tag, "_red"},   int'(data_red),   r);
    chk({tag, "_green"}, int'(data_green), g);
    chk({tag, "_blue"},  int'(data_blue),  b);
  endtask

  function automatic vec_t mk_cmd(input int r, input int g, input int b, input int st, input int hd);
    vec_t v;
    v = '0;
    v.is_cmd = 1'b1;
    v.r = 10'(r); v.g = 10'(g); v.b = 10'(b);
    v.st = 4'(st); v.hd = 8'(hd);
    return v;
  endfunction

  function automatic vec_t mk_frm(input int r, input int g, input int b, input bit bz, input bit dn);
    vec_t v;
    v = '0;
    v.er = 10'(r); v.eg = 10'(g); v.eb = 10'(b);
    v.ebusy = bz; v.edone = dn;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    drive_cmd(0, 0, 0, 0, 0);

    // Ramp up with hold of two frames
    tbl.push_back(mk_cmd(10, 0, 5, 4, 2));
    tbl.push_back(mk_frm(4, 0, 4, 1, 0));
    tbl.push_back(mk_frm(8, 0, 5, 1, 0));
    tbl.push_back(mk_frm(10, 0, 5, 1, 0));
    tbl.push_back(mk_frm(10, 0, 5, 1, 0));
    tbl.push_back(mk_frm(10, 0, 5, 0, 1));
    // Back-to-back ramp down, issued in the done cycle
    tbl.push_back(mk_cmd(1, 0, 0, 4, 0));
    tbl.push_back(mk_frm(6, 0, 1, 1, 0));
    tbl.push_back(mk_frm(2, 0, 0, 1, 0));
    tbl.push_back(mk_frm(1, 0, 0, 0, 1));
    // Jump
    tbl.push_back(mk_cmd(1023, 0, 512, 0, 0));
    tbl.push_back(mk_frm(1023, 0, 512, 0, 1));
    // Top clamp
    tbl.push_back(mk_cmd(1020, 0, 0, 0, 0));
    tbl.push_back(mk_frm(1020, 0, 0, 0, 1));
    tbl.push_back(mk_cmd(1023, 0, 0, 15, 0));
    tbl.push_back(mk_frm(1023, 0, 0, 0, 1));
    // Target equals current colour
    tbl.push_back(mk_cmd(1023, 0, 0, 3, 0));
    tbl.push_back(mk_frm(1023, 0, 0, 0, 1));
    // Down clamp and up clamp with large step, hold of one frame
    tbl.push_back(mk_cmd(1015, 7, 0, 15, 1));
    tbl.push_back(mk_frm(1015, 7, 0, 1, 0));
    tbl.push_back(mk_frm(1015, 7, 0, 0, 1));
    tbl.push_back(mk_cmd(0, 0, 0, 0, 0));
    tbl.push_back(mk_frm(0, 0, 0, 0, 1));

    repeat (3) cyc();
    chk_rgb("reset", 0, 0, 0);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_start", int'(frame_start), 1);
    chk("reset_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (32) cyc();

    foreach (tbl[i]) begin
      if (tbl[i].is_cmd) begin
        cmd_valid = 1'b1;
        drive_cmd(int'(tbl[i].r), int'(tbl[i].g), int'(tbl[i].b), int'(tbl[i].st), int'(tbl[i].hd));
        chk($sformatf("row%0d_ready", i), int'(cmd_ready), 1);
        cyc();
        cmd_valid = 1'b0;
        chk($sformatf("row%0d_busy_accept", i), int'(busy), 1);
      end else begin
        wait_frame();
        chk_rgb($sformatf("row%0d", i), int'(tbl[i].er), int'(tbl[i].eg), int'(tbl[i].eb));
        chk($sformatf("row%0d_busy", i), int'(busy), int'(tbl[i].ebusy));
        chk($sformatf("row%0d_done", i), int'(done), int'(tbl[i].edone));
      end
    end

    // Abort mid-fade while another command is held pending
    cmd_valid = 1'b1;
    drive_cmd(100, 0, 0, 8, 0);
    cyc();
    drive_cmd(50, 50, 50, 0, 0);
    wait_frame();
    chk_rgb("abort_f1", 8, 0, 0);
    chk("abort_f1_ready", int'(cmd_ready), 0);
    wait_frame();
    chk_rgb("abort_f2", 16, 0, 0);
    wait_frame();
    chk_rgb("abort_f3", 24, 0, 0);
    chk("abort_f3_busy", int'(busy), 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_no_done", int'(done), 0);
    chk_rgb("abort_frozen", 24, 0, 0);
    cyc();
    cmd_valid = 1'b0;
    chk("held_cmd_busy", int'(busy), 1);
    chk_rgb("held_cmd_accept", 24, 0, 0);
    wait_frame();
    chk_rgb("held_cmd", 50, 50, 50);
    chk("held_cmd_done", int'(done), 1);

    // Abort in IDLE is ignored and the same-cycle command is accepted
    abort = 1'b1;
    cmd_valid = 1'b1;
    drive_cmd(60, 60, 60, 0, 3);
    cyc();
    abort = 1'b0;
    cmd_valid = 1'b0;
    chk("idle_abort_busy", int'(busy), 1);
    wait_frame();
    chk_rgb("hold_entry", 60, 60, 60);
    chk("hold_entry_busy", int'(busy), 1);

    // Reset mid-hold
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk_rgb("midrst", 0, 0, 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_frame_start", int'(frame_start), 1);
    chk("midrst_done", int'(done), 0);
    repeat (4) wait_frame();
    chk_rgb("post_rst", 0, 0, 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("done_total", dcount, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
